data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Data-memory responder for the datapath's load/store path. It is the target end of the MemRead/MemWrite requests that the main controller decodes.
- Accepts one request at a time and holds the pipeline with `busy` for a programmable access latency. It then commits the store, or returns sign/zero-extended load data, with a one-cycle `done` pulse.
- Byte-addressed, little-endian. Supports byte, half and word accesses selected by Funct3.

Parameters:
- ADDR_WIDTH, 10, byte-address width; storage is 2^(ADDR_WIDTH-2) 32-bit words.
- LATENCY, 2, wait cycles between acceptance and completion; legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemRead  in  1  load request; held stable by the pipeline while `busy`=1.
- MemWrite  in  1  store request; held stable while `busy`=1.
- Funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only).
- addr  in  ADDR_WIDTH  byte address.
- wd  in  32  store data; low bits are used for B/H.
- rd  out  32  load result; updated only on load completion, then held.
- busy  out  1  pipeline stall request.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse with `done` on a misaligned or illegal access.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0; rd, done and err all 0.
  - Memory contents are not cleared.
  - Releasing reset takes effect on the next clk edge.
- States:
  - IDLE:
    - req = MemRead | MemWrite. If req and LATENCY>0, go to WAIT; if req and LATENCY=0, go to RESP.
    - On acceptance, latch the op, Funct3, addr and wd, and load counter=LATENCY-1.
    - MemWrite and MemRead both high: treat as a store (write priority, no read).
  - WAIT: decrement counter; when counter=0, perform the access and go to RESP.
    - For LATENCY=0 the access is performed on the IDLE->RESP edge.
  - RESP: done=1 (registered); always go to IDLE, ignoring the request inputs (the same instruction is still presented this cycle).
- busy (combinational):
  - 1 in IDLE when req=1, and 1 in WAIT; 0 in RESP and when idle.
  - Total stall = LATENCY+1 cycles per access; the pipeline advances at the edge ending RESP.
- Access rules (latched values):
  - Word index = addr[ADDR_WIDTH-1:2]; byte lane = addr[1:0]; the address space wraps naturally.
  - Store B writes lane addr[1:0] with wd[7:0].
  - Store H writes lanes {addr[1],0} and {addr[1],1} with wd[15:0].
  - Store W writes all four lanes with wd.
  - Load B/H sign-extends from bit 7/15 of the selected lane(s); BU/HU zero-extend; W is the full word.
- Error conditions (no memory update; on a load rd is forced to 0; err=1 together with done):
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - Funct3 in {011, 110, 111}.
  - Store with Funct3 in {100, 101}.
- Store commits only at entry to RESP; a store completion leaves rd unchanged.
- Reset mid-operation (in WAIT) aborts the access: no memory write, done never pulses, busy drops immediately.
- Back-to-back requests: next acceptance no earlier than the IDLE cycle after RESP (minimum 2 cycles per access at LATENCY=0).

Test Plan:
- Reset, then SW addr=0x010 wd=0xDEADBEEF, LATENCY=2 -> busy high for 3 cycles, done at cycle 3 with err=0; then LW addr=0x010 -> rd=0xDEADBEEF at its done.
- After the above, LB addr=0x013 -> rd=0xFFFFFFDE; LBU addr=0x013 -> rd=0x000000DE; LH addr=0x010 -> rd=0xFFFFBEEF; LHU addr=0x012 -> rd=0x0000DEAD.
- SB addr=0x011 wd=0x00000055, then LW addr=0x010 -> rd=0xDEAD55EF.
- LW addr=0x012 -> done with err=1, rd=0; SH addr=0x011 wd=0x1234 -> err=1, and a following LW 0x010 is unchanged.
- SW addr=0x020 wd=0x11111111, reset pulsed low during WAIT -> busy/done/rd=0 immediately; a later LW 0x020 returns the prior contents (not 0x11111111).
- LATENCY=0 build, MemRead and MemWrite both high, SW 0x004 wd=0xA5A5A5A5 -> busy 1 cycle, done next cycle, rd unchanged; a subsequent LW 0x004 -> 0xA5A5A5A5.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, stalls for LATENCY
// cycles, then commits the store or returns extended load data with a done pulse.
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wd,
  output logic [31:0]           rd,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;
  localparam int unsigned WORDS = 2 ** IDX_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        count;
  logic                    op_wr;
  logic [2:0]              op_f3;
  logic [ADDR_WIDTH-1:0]   op_addr;
  logic [31:0]             op_wd;
  logic [31:0]             mem [WORDS];

  logic                    req;
  logic                    fire;
  logic                    a_wr;
  logic [2:0]              a_f3;
  logic [ADDR_WIDTH-1:0]   a_addr;
  logic [31:0]             a_wd;
  logic [1:0]              lane;
  logic [31:0]             word;
  logic [7:0]              byte_v;
  logic [15:0]             half_v;
  logic                    bad;
  logic [31:0]             load_val;
  logic [31:0]             new_word;
  logic                    we;

  assign req  = MemRead | MemWrite;
  assign busy = ((state == IDLE) && req) || (state == WAIT);

  // Access happens on the edge entering RESP; with zero latency that is the accept edge.
  assign fire = reset && (((state == IDLE) && req && (LATENCY == 0)) ||
                          ((state == WAIT) && (count == '0)));

  // Zero-latency accesses use the live request, otherwise the latched one.
  assign a_wr   = (state == IDLE) ? MemWrite : op_wr;
  assign a_f3   = (state == IDLE) ? Funct3   : op_f3;
  assign a_addr = (state == IDLE) ? addr     : op_addr;
  assign a_wd   = (state == IDLE) ? wd       : op_wd;

  assign lane   = a_addr[1:0];
  assign word   = mem[a_addr[ADDR_WIDTH-1:2]];
  assign byte_v = word[{lane, 3'b000} +: 8];
  assign half_v = word[{a_addr[1], 4'b0000} +: 16];

  assign bad = (a_f3[1:0] == 2'b11) || (a_f3 == 3'b110) || (a_wr && a_f3[2]) ||
               ((a_f3[1:0] == 2'b01) && a_addr[0]) ||
               ((a_f3[1:0] == 2'b10) && (lane != 2'b00));

  assign we = fire && a_wr && !bad;

  always_comb begin
    load_val = word;
    case (a_f3)
      3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
      3'b100:  load_val = {24'd0, byte_v};
      3'b001:  load_val = {{16{half_v[15]}}, half_v};
      3'b101:  load_val = {16'd0, half_v};
      default: load_val = word;
    endcase
  end

  // Merge store data into the addressed lanes of the current word.
  always_comb begin
    new_word = word;
    case (a_f3[1:0])
      2'b00:   new_word[{lane, 3'b000} +: 8]       = a_wd[7:0];
      2'b01:   new_word[{a_addr[1], 4'b0000} +: 16] = a_wd[15:0];
      default: new_word = a_wd;
    endcase
  end

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[a_addr[ADDR_WIDTH-1:2]] <= new_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= '0;
      op_wr   <= 1'b0;
      op_f3   <= 3'b000;
      op_addr <= '0;
      op_wd   <= '0;
      rd      <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            op_wr   <= MemWrite;
            op_f3   <= Funct3;
            op_addr <= addr;
            op_wd   <= wd;
            count   <= CNT_W'((LATENCY == 0) ? 0 : LATENCY - 1);
            state   <= (LATENCY == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (count == '0) state <= RESP;
          else             count <= count - 1'b1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (fire) begin
        done <= 1'b1;
        err  <= bad;
        if (!a_wr) rd <= bad ? 32'd0 : load_val;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=2 and a LATENCY=0 instance driven by
// directed and random accesses, checked against a byte-array memory model.
module tb_data_mem_responder;

  localparam int unsigned AW = 10;

  logic        clk = 1'b0;
  logic [1:0]  rst;
  logic [1:0]  mem_read;
  logic [1:0]  mem_write;
  logic [1:0]  busy;
  logic [1:0]  done;
  logic [1:0]  err;
  logic [2:0]  f3   [2];
  logic [AW-1:0] addr [2];
  logic [31:0] wd   [2];
  logic [31:0] rd   [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY((g == 0) ? 2 : 0)) dut (
      .clk(clk), .reset(rst[g]), .MemRead(mem_read[g]), .MemWrite(mem_write[g]),
      .Funct3(f3[g]), .addr(addr[g]), .wd(wd[g]), .rd(rd[g]),
      .busy(busy[g]), .done(done[g]), .err(err[g])
    );
  end

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  ref_mem [2][1024];
  logic [31:0] ref_rd  [2];
  exp_t        q0 [$];
  exp_t        q1 [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: byte-granular little-endian memory, alignment by access size.
  task automatic model(input int d, input bit wr, input logic [2:0] fn, input int a,
                       input logic [31:0] data, output exp_t e);
    int size;
    bit bad;
    logic [31:0] v;
    size = 1 << fn[1:0];
    bad  = (fn[1:0] == 2'd3) || (fn == 3'b110) || (wr && fn[2]) || ((a % size) != 0);
    e.err = bad;
    e.rd  = ref_rd[d];
    if (bad) begin
      if (!wr) e.rd = 32'd0;
    end else if (wr) begin
      for (int i = 0; i < size; i++) ref_mem[d][a + i] = data[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[d][a + i];
      if (!fn[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
      e.rd = v;
    end
    ref_rd[d] = e.rd;
  endtask

  // Issue one access, hold it until done, and check the stall length.
  task automatic access(input int d, input bit wr, input bit rq, input logic [2:0] fn,
                        input int a, input logic [31:0] data);
    exp_t e;
    int nb;
    bit got;
    model(d, wr, fn, a, data, e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    mem_read[d]  = rq;
    mem_write[d] = wr;
    f3[d]        = fn;
    addr[d]      = AW'(a);
    wd[d]        = data;
    nb  = 0;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (busy[d]) nb++;
      if (done[d]) got = 1'b1;
    end
    check($sformatf("done_seen_dut%0d", d), 32'(got), 32'd1);
    check($sformatf("busy_cycles_dut%0d", d), 32'(nb), (d == 0) ? 32'd3 : 32'd1);
    @(posedge clk);
    #1;
    mem_read[d]  = 1'b0;
    mem_write[d] = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    bit empty;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (done[d]) begin
          empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
          if (empty) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done_dut%0d: got done=1 expected no completion", d);
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("err_dut%0d", d), 32'(err[d]), 32'(e.err));
            check($sformatf("rd_dut%0d", d), rd[d], e.rd);
          end
        end
      end
    end
  endtask

  initial begin
    exp_t dummy;
    logic [31:0] prior;
    logic [2:0]  fn;
    int          kind;
    rst       = 2'b00;
    mem_read  = 2'b00;
    mem_write = 2'b00;
    for (int d = 0; d < 2; d++) begin
      f3[d] = 3'b000; addr[d] = '0; wd[d] = '0; ref_rd[d] = 32'd0;
    end
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_rd_dut%0d", d), rd[d], 32'd0);
      check($sformatf("reset_done_dut%0d", d), 32'(done[d]), 32'd0);
      check($sformatf("reset_err_dut%0d", d), 32'(err[d]), 32'd0);
      check($sformatf("reset_busy_dut%0d", d), 32'(busy[d]), 32'd0);
    end
    rst = 2'b11;
    @(posedge clk);
    #1;

    // Give every word a known value so later loads are fully defined.
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 256; w++) access(d, 1'b1, 1'b0, 3'b010, w * 4, $urandom);

    access(0, 1'b1, 1'b0, 3'b010, 'h010, 32'hDEADBEEF);
    access(0, 1'b0, 1'b1, 3'b010, 'h010, 32'd0);
    check("lw_010", rd[0], 32'hDEADBEEF);
    access(0, 1'b0, 1'b1, 3'b000, 'h013, 32'd0);
    check("lb_013", rd[0], 32'hFFFFFFDE);
    access(0, 1'b0, 1'b1, 3'b100, 'h013, 32'd0);
    check("lbu_013", rd[0], 32'h000000DE);
    access(0, 1'b0, 1'b1, 3'b001, 'h010, 32'd0);
    check("lh_010", rd[0], 32'hFFFFBEEF);
    access(0, 1'b0, 1'b1, 3'b101, 'h012, 32'd0);
    check("lhu_012", rd[0], 32'h0000DEAD);
    access(0, 1'b1, 1'b0, 3'b000, 'h011, 32'h00000055);
    access(0, 1'b0, 1'b1, 3'b010, 'h010, 32'd0);
    check("lw_after_sb", rd[0], 32'hDEAD55EF);
    access(0, 1'b0, 1'b1, 3'b010, 'h012, 32'd0);
    check("lw_misaligned_rd", rd[0], 32'd0);
    access(0, 1'b1, 1'b0, 3'b001, 'h011, 32'h00001234);
    access(0, 1'b0, 1'b1, 3'b010, 'h010, 32'd0);
    check("lw_after_bad_sh", rd[0], 32'hDEAD55EF);

    // Reset during WAIT must abort the store.
    prior = {ref_mem[0]['h23], ref_mem[0]['h22], ref_mem[0]['h21], ref_mem[0]['h20]};
    mem_write[0] = 1'b1; f3[0] = 3'b010; addr[0] = AW'('h020); wd[0] = 32'h11111111;
    @(posedge clk);
    #1;
    check("busy_in_wait", 32'(busy[0]), 32'd1);
    rst[0] = 1'b0;
    mem_write[0] = 1'b0;
    #1;
    check("abort_busy", 32'(busy[0]), 32'd0);
    check("abort_done", 32'(done[0]), 32'd0);
    check("abort_rd", rd[0], 32'd0);
    ref_rd[0] = 32'd0;
    @(posedge clk);
    #1;
    rst[0] = 1'b1;
    @(posedge clk);
    #1;
    access(0, 1'b0, 1'b1, 3'b010, 'h020, 32'd0);
    check("lw_after_abort", rd[0], prior);

    // Zero-latency instance: simultaneous read+write is a store.
    prior = ref_rd[1];
    access(1, 1'b1, 1'b1, 3'b010, 'h004, 32'hA5A5A5A5);
    check("l0_rd_held", rd[1], prior);
    access(1, 1'b0, 1'b1, 3'b010, 'h004, 32'd0);
    check("l0_lw_004", rd[1], 32'hA5A5A5A5);

    for (int n = 0; n < 300; n++) begin
      for (int d = 0; d < 2; d++) begin
        fn   = 3'($urandom_range(0, 7));
        kind = $urandom_range(0, 2);
        access(d, kind != 0, kind != 1, fn, $urandom_range(0, 1023), $urandom);
      end
    end

    repeat (3) @(posedge clk);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    dummy = '0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
